// File: rtl/fpu_rr_arbiter_pkg.sv
// ============================================================================
// Module  : fpu_rr_arbiter_pkg
// Brief   : Shared FPU interface widths, command encodings and flag layout
//           used by the round-robin FPU sharing arbiter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package fpu_rr_arbiter_pkg;

  // Operand / result width, rounding-mode width and command width of the FPU
  localparam int C_OP    = 32;
  localparam int C_RM    = 2;
  localparam int C_CMD   = 4;
  localparam int C_FLAGS = 6;

  // FPU command encodings
  localparam logic [C_CMD-1:0] C_FPU_ADD_CMD = 4'd0;
  localparam logic [C_CMD-1:0] C_FPU_SUB_CMD = 4'd1;
  localparam logic [C_CMD-1:0] C_FPU_MUL_CMD = 4'd2;
  localparam logic [C_CMD-1:0] C_FPU_DIV_CMD = 4'd3;
  localparam logic [C_CMD-1:0] C_FPU_I2F_CMD = 4'd4;
  localparam logic [C_CMD-1:0] C_FPU_F2I_CMD = 4'd5;

  // Exception flags as delivered by the FPU, MSB first
  typedef struct packed {
    logic of;
    logic uf;
    logic zero;
    logic ix;
    logic iv;
    logic inf;
  } fpu_flags_t;

endpackage

`default_nettype wire

// File: rtl/fpu_rr_arbiter_rr_arb_core.sv
// ============================================================================
// Module  : rr_arb_core
// Brief   : Combinational round-robin picker. Searches the request vector
//           starting at the pointer and wrapping at NUM_REQ-1 -> 0, returning
//           a one-hot grant and the granted index. Reusable for any shared
//           unit that keeps its own pointer register.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arb_core #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [ID_W-1:0]    i_ptr,
  input  logic               i_en,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [ID_W-1:0]    o_idx,
  output logic               o_valid
);

  int w_cand;

  // First requester at or above the pointer wins; index stays 0 when idle so
  // downstream muxes see a deterministic selection.
  always_comb begin
    o_gnt   = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    w_cand  = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_cand = int'(i_ptr) + k;
      if (w_cand >= NUM_REQ) begin
        w_cand = w_cand - NUM_REQ;
      end
      if (i_en && !o_valid && i_req[w_cand]) begin
        o_valid       = 1'b1;
        o_gnt[w_cand] = 1'b1;
        o_idx         = w_cand[ID_W-1:0];
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/fpu_rr_arbiter.sv
// ============================================================================
// Module  : fpu_rr_arbiter
// Brief   : Shares one pipelined FPU among NUM_REQ requesters. A round-robin
//           grant selects whose operands enter the FPU, a tag pipeline of
//           LATENCY stages remembers the owner of every in-flight operation,
//           and completions are routed back to that owner. When the owner of
//           a completed result is not ready, the FPU is stalled and no new
//           grant is given (head-of-line blocking is intended).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module fpu_rr_arbiter
  import fpu_rr_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int LATENCY = 3
) (
  input  logic                       Clk_CI,
  input  logic                       Rst_RI,
  input  logic [NUM_REQ-1:0]         Req_SI,
  input  logic [NUM_REQ*C_OP-1:0]    Operand_a_DI,
  input  logic [NUM_REQ*C_OP-1:0]    Operand_b_DI,
  input  logic [NUM_REQ*C_RM-1:0]    RM_SI,
  input  logic [NUM_REQ*C_CMD-1:0]   OP_SI,
  output logic [NUM_REQ-1:0]         Gnt_SO,
  input  logic [NUM_REQ-1:0]         Ready_SI,
  output logic [NUM_REQ-1:0]         Valid_SO,
  output logic [C_OP-1:0]            Result_DO,
  output logic [C_FLAGS-1:0]         Flags_SO,
  output logic [C_OP-1:0]            Fpu_Operand_a_DO,
  output logic [C_OP-1:0]            Fpu_Operand_b_DO,
  output logic [C_RM-1:0]            Fpu_RM_SO,
  output logic [C_CMD-1:0]           Fpu_OP_SO,
  output logic                       Fpu_Enable_SO,
  output logic                       Fpu_Stall_SO,
  input  logic [C_OP-1:0]            Fpu_Result_DI,
  input  logic [C_FLAGS-1:0]         Fpu_Flags_DI
);

  // Requester index width, derived from the requester count
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  // Owner record carried alongside each FPU pipeline stage
  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
  } fpu_tag_t;

  fpu_tag_t             r_tag [LATENCY];
  fpu_tag_t             w_tag_in;
  fpu_tag_t             w_tail;
  logic [ID_W-1:0]      r_ptr;
  logic [ID_W-1:0]      w_ptr_nxt;
  logic [NUM_REQ-1:0]   w_gnt;
  logic [ID_W-1:0]      w_gnt_idx;
  logic                 w_gnt_valid;
  logic                 w_stall;
  logic                 w_arb_en;
  fpu_flags_t           w_flags;

  // --------------------------------------------------------------------------
  // Completion side: the last tag stage lines up with Result_DI
  // --------------------------------------------------------------------------
  assign w_tail  = r_tag[LATENCY-1];
  assign w_stall = w_tail.valid & ~Ready_SI[w_tail.id];

  assign Fpu_Stall_SO  = w_stall;
  assign Fpu_Enable_SO = 1'b1;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_valid
      assign Valid_SO[gi] = w_tail.valid & (w_tail.id == ID_W'(gi));
    end
  endgenerate

  // Result and flags are shared wires; only Valid_SO says who owns them
  assign w_flags   = Fpu_Flags_DI;
  assign Flags_SO  = w_flags;
  assign Result_DO = Fpu_Result_DI;

  // --------------------------------------------------------------------------
  // Arbitration: no grant while stalled (the FPU input register is frozen)
  // or while reset is held
  // --------------------------------------------------------------------------
  assign w_arb_en = ~w_stall & ~Rst_RI;

  rr_arb_core #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_arb_core (
    .i_req   (Req_SI),
    .i_ptr   (r_ptr),
    .i_en    (w_arb_en),
    .o_gnt   (w_gnt),
    .o_idx   (w_gnt_idx),
    .o_valid (w_gnt_valid)
  );

  assign Gnt_SO = w_gnt;

  // Operand mux: with no grant the index is 0, so requester 0 is presented
  // but no tag is issued and the FPU output is ignored.
  assign Fpu_Operand_a_DO = Operand_a_DI[w_gnt_idx*C_OP  +: C_OP];
  assign Fpu_Operand_b_DO = Operand_b_DI[w_gnt_idx*C_OP  +: C_OP];
  assign Fpu_RM_SO        = RM_SI       [w_gnt_idx*C_RM  +: C_RM];
  assign Fpu_OP_SO        = OP_SI       [w_gnt_idx*C_CMD +: C_CMD];

  // --------------------------------------------------------------------------
  // Round-robin pointer: the requester after the last winner gets priority
  // --------------------------------------------------------------------------
  assign w_ptr_nxt = (w_gnt_idx == ID_W'(NUM_REQ-1)) ? '0 : (w_gnt_idx + ID_W'(1));

  // Move the pointer past the winner on every grant, hold otherwise
  always_ff @(posedge Clk_CI or posedge Rst_RI) begin
    if (Rst_RI) begin
      r_ptr <= '0;
    end else if (w_gnt_valid) begin
      r_ptr <= w_ptr_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Tag pipeline: advances in lock-step with the FPU, freezes on stall
  // --------------------------------------------------------------------------
  assign w_tag_in.valid = w_gnt_valid;
  assign w_tag_in.id    = w_gnt_idx;

  genvar gs;
  generate
    for (gs = 0; gs < LATENCY; gs++) begin : g_tag
      if (gs == 0) begin : g_head
        // Head stage captures the owner of the operation entering the FPU
        always_ff @(posedge Clk_CI or posedge Rst_RI) begin
          if (Rst_RI) begin
            r_tag[gs] <= '0;
          end else if (!w_stall) begin
            r_tag[gs] <= w_tag_in;
          end
        end
      end else begin : g_body
        // Later stages shift the owner record one step toward completion
        always_ff @(posedge Clk_CI or posedge Rst_RI) begin
          if (Rst_RI) begin
            r_tag[gs] <= '0;
          end else if (!w_stall) begin
            r_tag[gs] <= r_tag[gs-1];
          end
        end
      end
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_fpu_rr_arbiter.sv
// ============================================================================
// Module  : tb_fpu_rr_arbiter
// Brief   : Self-checking bench for fpu_rr_arbiter with a stand-in pipelined
//           FPU (fixed latency, freezes on stall).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fpu_rr_arbiter;
  import fpu_rr_arbiter_pkg::*;

  localparam int N   = 4;
  localparam int LAT = 3;

  logic                 Clk_CI;
  logic                 Rst_RI;
  logic [N-1:0]         Req_SI;
  logic [N*C_OP-1:0]    Operand_a_DI;
  logic [N*C_OP-1:0]    Operand_b_DI;
  logic [N*C_RM-1:0]    RM_SI;
  logic [N*C_CMD-1:0]   OP_SI;
  logic [N-1:0]         Gnt_SO;
  logic [N-1:0]         Ready_SI;
  logic [N-1:0]         Valid_SO;
  logic [C_OP-1:0]      Result_DO;
  logic [C_FLAGS-1:0]   Flags_SO;
  logic [C_OP-1:0]      Fpu_Operand_a_DO;
  logic [C_OP-1:0]      Fpu_Operand_b_DO;
  logic [C_RM-1:0]      Fpu_RM_SO;
  logic [C_CMD-1:0]     Fpu_OP_SO;
  logic                 Fpu_Enable_SO;
  logic                 Fpu_Stall_SO;
  logic [C_OP-1:0]      Fpu_Result_DI;
  logic [C_FLAGS-1:0]   Fpu_Flags_DI;

  int n_tests = 0;
  int n_fail  = 0;

  logic [C_OP-1:0]  opa [N];
  logic [C_OP-1:0]  opb [N];
  logic [C_RM-1:0]  oprm[N];
  logic [C_CMD-1:0] opc [N];

  fpu_rr_arbiter #(.NUM_REQ(N), .LATENCY(LAT)) dut (
    .Clk_CI(Clk_CI), .Rst_RI(Rst_RI), .Req_SI(Req_SI),
    .Operand_a_DI(Operand_a_DI), .Operand_b_DI(Operand_b_DI),
    .RM_SI(RM_SI), .OP_SI(OP_SI), .Gnt_SO(Gnt_SO), .Ready_SI(Ready_SI),
    .Valid_SO(Valid_SO), .Result_DO(Result_DO), .Flags_SO(Flags_SO),
    .Fpu_Operand_a_DO(Fpu_Operand_a_DO), .Fpu_Operand_b_DO(Fpu_Operand_b_DO),
    .Fpu_RM_SO(Fpu_RM_SO), .Fpu_OP_SO(Fpu_OP_SO), .Fpu_Enable_SO(Fpu_Enable_SO),
    .Fpu_Stall_SO(Fpu_Stall_SO), .Fpu_Result_DI(Fpu_Result_DI),
    .Fpu_Flags_DI(Fpu_Flags_DI)
  );

  initial Clk_CI = 1'b0;
  always #5 Clk_CI = ~Clk_CI;

  // Stand-in FPU arithmetic: a few exact single-precision adds, otherwise a
  // deterministic mix of the operands so each operation is recognisable.
  function automatic logic [C_OP-1:0] fake_res(logic [C_OP-1:0] a, logic [C_OP-1:0] b,
                                               logic [C_CMD-1:0] op);
    if (op == C_FPU_ADD_CMD && a == 32'h3F80_0000 && b == 32'h4000_0000) return 32'h4040_0000;
    if (op == C_FPU_ADD_CMD && a == 32'h4000_0000 && b == 32'h4000_0000) return 32'h4080_0000;
    return a ^ {b[15:0], b[31:16]} ^ {28'd0, op};
  endfunction

  function automatic logic [C_FLAGS-1:0] fake_flags(logic [C_OP-1:0] a, logic [C_OP-1:0] b,
                                                    logic [C_CMD-1:0] op);
    if (op == C_FPU_ADD_CMD && a == 32'h3F80_0000 && b == 32'h4000_0000) return 6'd0;
    if (op == C_FPU_ADD_CMD && a == 32'h4000_0000 && b == 32'h4000_0000) return 6'd0;
    return a[5:0] ^ b[11:6];
  endfunction

  // Stand-in FPU pipeline: samples the muxed operands, freezes on stall
  logic [C_OP-1:0]    fp_res [LAT];
  logic [C_FLAGS-1:0] fp_flg [LAT];
  always_ff @(posedge Clk_CI) begin
    if (!Fpu_Stall_SO) begin
      fp_res[0] <= fake_res(Fpu_Operand_a_DO, Fpu_Operand_b_DO, Fpu_OP_SO);
      fp_flg[0] <= fake_flags(Fpu_Operand_a_DO, Fpu_Operand_b_DO, Fpu_OP_SO);
      for (int s = 1; s < LAT; s++) begin
        fp_res[s] <= fp_res[s-1];
        fp_flg[s] <= fp_flg[s-1];
      end
    end
  end
  assign Fpu_Result_DI = fp_res[LAT-1];
  assign Fpu_Flags_DI  = fp_flg[LAT-1];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit expired (got running, need finished)");
    $fatal(1, "watchdog");
  end

  task automatic next_cycle;
    @(posedge Clk_CI);
    #1;
  endtask

  task automatic apply_ops;
    for (int i = 0; i < N; i++) begin
      Operand_a_DI[i*C_OP +: C_OP]   = opa[i];
      Operand_b_DI[i*C_OP +: C_OP]   = opb[i];
      RM_SI[i*C_RM +: C_RM]          = oprm[i];
      OP_SI[i*C_CMD +: C_CMD]        = opc[i];
    end
  endtask

  task automatic set_pattern_ops;
    for (int i = 0; i < N; i++) begin
      opa[i]  = 32'h1000_0000 * (i + 1);
      opb[i]  = 32'h0000_0011 * (i + 1);
      oprm[i] = C_RM'(i);
      opc[i]  = C_FPU_ADD_CMD;
    end
    apply_ops();
  endtask

  task automatic do_reset;
    Rst_RI   = 1'b1;
    Req_SI   = '0;
    Ready_SI = '1;
    next_cycle();
    next_cycle();
    Rst_RI   = 1'b0;
  endtask

  task automatic test_reset;
    Rst_RI = 1'b1; Req_SI = 4'b1111; Ready_SI = 4'b1111;
    set_pattern_ops();
    #1;
    n_tests++; if (Gnt_SO !== 4'b0000) begin n_fail++; $display("FAIL reset_gnt got %b need 0000", Gnt_SO); end
    n_tests++; if (Valid_SO !== 4'b0000) begin n_fail++; $display("FAIL reset_valid got %b need 0000", Valid_SO); end
    n_tests++; if (Fpu_Stall_SO !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %b need 0", Fpu_Stall_SO); end
    n_tests++; if (Fpu_Enable_SO !== 1'b1) begin n_fail++; $display("FAIL reset_enable got %b need 1", Fpu_Enable_SO); end
    next_cycle();
    n_tests++; if (Gnt_SO !== 4'b0000) begin n_fail++; $display("FAIL reset_gnt_held got %b need 0000", Gnt_SO); end
    Rst_RI = 1'b0;
    #1;
    n_tests++; if (Gnt_SO !== 4'b0001) begin n_fail++; $display("FAIL reset_first_gnt got %b need 0001", Gnt_SO); end
    Req_SI = '0;
  endtask

  task automatic test_single_add;
    do_reset();
    next_cycle();
    opa[0] = 32'h3F80_0000; opb[0] = 32'h4000_0000; opc[0] = C_FPU_ADD_CMD; oprm[0] = '0;
    apply_ops();
    Req_SI = 4'b0001;
    #1;
    n_tests++; if (Gnt_SO !== 4'b0001) begin n_fail++; $display("FAIL add_gnt got %b need 0001", Gnt_SO); end
    for (int c = 1; c <= 4; c++) begin
      next_cycle();
      Req_SI = '0;
      #1;
      if (c == 3) begin
        n_tests++; if (Valid_SO !== 4'b0001) begin n_fail++; $display("FAIL add_valid c%0d got %b need 0001", c, Valid_SO); end
        n_tests++; if (Result_DO !== 32'h4040_0000) begin n_fail++; $display("FAIL add_result got %h need 40400000", Result_DO); end
        n_tests++; if (Flags_SO !== 6'd0) begin n_fail++; $display("FAIL add_flags got %b need 000000", Flags_SO); end
      end else begin
        n_tests++; if (Valid_SO !== 4'b0000) begin n_fail++; $display("FAIL add_idle c%0d got %b need 0000", c, Valid_SO); end
      end
    end
  endtask

  task automatic test_round_robin;
    logic [N-1:0] eg, ev;
    int           own;
    do_reset();
    set_pattern_ops();
    for (int k = 0; k <= 10; k++) begin
      next_cycle();
      Req_SI = (k < 8) ? 4'b1111 : 4'b0000;
      #1;
      eg = (k < 8) ? 4'(1 << (k % 4)) : 4'b0000;
      n_tests++; if (Gnt_SO !== eg) begin n_fail++; $display("FAIL rr_gnt c%0d got %b need %b", k, Gnt_SO, eg); end
      own = (k - 3) % 4;
      ev  = (k >= 3) ? 4'(1 << own) : 4'b0000;
      n_tests++; if (Valid_SO !== ev) begin n_fail++; $display("FAIL rr_valid c%0d got %b need %b", k, Valid_SO, ev); end
      if (k >= 3) begin
        n_tests++;
        if (Result_DO !== fake_res(opa[own], opb[own], opc[own])) begin
          n_fail++; $display("FAIL rr_result c%0d got %h need %h", k, Result_DO, fake_res(opa[own], opb[own], opc[own]));
        end
      end
    end
  endtask

  task automatic test_pointer_wrap;
    logic [N-1:0] eg [6] = '{4'b0100, 4'b1000, 4'b0001, 4'b0000, 4'b0000, 4'b0000};
    logic [N-1:0] ev [6] = '{4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b1000, 4'b0001};
    logic [N-1:0] rq [6] = '{4'b0100, 4'b1001, 4'b1001, 4'b0000, 4'b0000, 4'b0000};
    do_reset();
    set_pattern_ops();
    for (int c = 0; c < 6; c++) begin
      next_cycle();
      Req_SI = rq[c];
      #1;
      n_tests++; if (Gnt_SO !== eg[c]) begin n_fail++; $display("FAIL wrap_gnt c%0d got %b need %b", c, Gnt_SO, eg[c]); end
      n_tests++; if (Valid_SO !== ev[c]) begin n_fail++; $display("FAIL wrap_valid c%0d got %b need %b", c, Valid_SO, ev[c]); end
    end
  endtask

  task automatic test_backpressure;
    logic [N-1:0] rq [10] = '{4'b0100, 4'b0000, 4'b0000, 4'b0011, 4'b0011, 4'b0011, 4'b0011, 4'b0000, 4'b0000, 4'b0000};
    logic [N-1:0] rd [10] = '{4'b1111, 4'b1111, 4'b1111, 4'b1011, 4'b1011, 4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b1111};
    logic [N-1:0] eg [10] = '{4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0010, 4'b0000, 4'b0000, 4'b0000};
    logic [N-1:0] ev [10] = '{4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b0001, 4'b0010};
    logic         es [10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [C_OP-1:0] er;
    do_reset();
    set_pattern_ops();
    for (int c = 0; c < 10; c++) begin
      next_cycle();
      Req_SI = rq[c]; Ready_SI = rd[c];
      #1;
      n_tests++; if (Fpu_Stall_SO !== es[c]) begin n_fail++; $display("FAIL bp_stall c%0d got %b need %b", c, Fpu_Stall_SO, es[c]); end
      n_tests++; if (Gnt_SO !== eg[c]) begin n_fail++; $display("FAIL bp_gnt c%0d got %b need %b", c, Gnt_SO, eg[c]); end
      n_tests++; if (Valid_SO !== ev[c]) begin n_fail++; $display("FAIL bp_valid c%0d got %b need %b", c, Valid_SO, ev[c]); end
      if (ev[c] != 4'b0000) begin
        er = (c >= 3 && c <= 5) ? fake_res(opa[2], opb[2], opc[2]) :
             (c == 8) ? fake_res(opa[0], opb[0], opc[0]) : fake_res(opa[1], opb[1], opc[1]);
        n_tests++; if (Result_DO !== er) begin n_fail++; $display("FAIL bp_result c%0d got %h need %h", c, Result_DO, er); end
      end
    end
  endtask

  task automatic test_reset_midflight;
    logic [N-1:0] eg [3] = '{4'b0001, 4'b0010, 4'b0100};
    do_reset();
    set_pattern_ops();
    for (int c = 0; c < 3; c++) begin
      next_cycle();
      Req_SI = 4'b0111;
      #1;
      n_tests++; if (Gnt_SO !== eg[c]) begin n_fail++; $display("FAIL mid_gnt c%0d got %b need %b", c, Gnt_SO, eg[c]); end
    end
    next_cycle();
    Rst_RI = 1'b1; Req_SI = 4'b0110;
    #1;
    n_tests++; if (Gnt_SO !== 4'b0000) begin n_fail++; $display("FAIL mid_rst_gnt got %b need 0000", Gnt_SO); end
    n_tests++; if (Valid_SO !== 4'b0000) begin n_fail++; $display("FAIL mid_rst_valid got %b need 0000", Valid_SO); end
    next_cycle();
    Rst_RI = 1'b0;
    #1;
    n_tests++; if (Gnt_SO !== 4'b0010) begin n_fail++; $display("FAIL mid_new_gnt got %b need 0010", Gnt_SO); end
    n_tests++; if (Valid_SO !== 4'b0000) begin n_fail++; $display("FAIL mid_after_c0 got %b need 0000", Valid_SO); end
    for (int c = 1; c <= 3; c++) begin
      next_cycle();
      Req_SI = '0;
      #1;
      n_tests++;
      if (Valid_SO !== ((c == 3) ? 4'b0010 : 4'b0000)) begin
        n_fail++; $display("FAIL mid_after_c%0d got %b need %b", c, Valid_SO, (c == 3) ? 4'b0010 : 4'b0000);
      end
    end
  endtask

  task automatic test_random;
    logic               m_v  [LAT];
    int                 m_id [LAT];
    logic [C_OP-1:0]    m_r  [LAT];
    logic [C_FLAGS-1:0] m_f  [LAT];
    int                 m_ptr, pick, w;
    int                 waitc [N];
    logic               estall;
    logic [N-1:0]       eg, ev;
    int                 n_gnt, n_ret;
    do_reset();
    m_ptr = 0; n_gnt = 0; n_ret = 0;
    for (int s = 0; s < LAT; s++) begin m_v[s] = 1'b0; m_id[s] = 0; m_r[s] = '0; m_f[s] = '0; end
    for (int i = 0; i < N; i++) waitc[i] = 0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      next_cycle();
      Req_SI = 4'($urandom);
      for (int i = 0; i < N; i++) begin
        Ready_SI[i] = ($urandom_range(0, 3) != 0);
        opa[i] = $urandom; opb[i] = $urandom; oprm[i] = 2'($urandom); opc[i] = 4'($urandom_range(0, 5));
      end
      apply_ops();
      #1;
      estall = m_v[LAT-1] && !Ready_SI[m_id[LAT-1]];
      pick = -1;
      if (!estall) begin
        for (int k = 0; k < N; k++) begin
          w = (m_ptr + k) % N;
          if (pick < 0 && Req_SI[w]) pick = w;
        end
      end
      eg = (pick >= 0) ? 4'(1 << pick) : 4'b0000;
      ev = m_v[LAT-1] ? 4'(1 << m_id[LAT-1]) : 4'b0000;
      n_tests++; if (Fpu_Stall_SO !== estall) begin n_fail++; $display("FAIL rnd_stall c%0d got %b need %b", cyc, Fpu_Stall_SO, estall); end
      n_tests++; if (Gnt_SO !== eg) begin n_fail++; $display("FAIL rnd_gnt c%0d got %b need %b", cyc, Gnt_SO, eg); end
      n_tests++; if (Valid_SO !== ev) begin n_fail++; $display("FAIL rnd_valid c%0d got %b need %b", cyc, Valid_SO, ev); end
      if (m_v[LAT-1]) begin
        n_tests++;
        if (Result_DO !== m_r[LAT-1] || Flags_SO !== m_f[LAT-1]) begin
          n_fail++; $display("FAIL rnd_result c%0d got %h/%b need %h/%b", cyc, Result_DO, Flags_SO, m_r[LAT-1], m_f[LAT-1]);
        end
      end
      // fairness observed on the DUT grant itself
      if (!Fpu_Stall_SO) begin
        for (int i = 0; i < N; i++) begin
          if (!Req_SI[i] || Gnt_SO[i]) waitc[i] = 0;
          else if (Gnt_SO != 4'b0000) waitc[i]++;
        end
        n_tests++;
        for (int i = 0; i < N; i++) begin
          if (waitc[i] >= N) begin
            n_fail++; $display("FAIL rnd_fair c%0d req%0d waited %0d grants, need < %0d", cyc, i, waitc[i], N);
            break;
          end
        end
      end
      if (Gnt_SO != 4'b0000) n_gnt++;
      if ((Valid_SO & Ready_SI) != 4'b0000) n_ret++;
      // advance the reference for the coming edge
      if (!estall) begin
        for (int s = LAT-1; s > 0; s--) begin
          m_v[s] = m_v[s-1]; m_id[s] = m_id[s-1]; m_r[s] = m_r[s-1]; m_f[s] = m_f[s-1];
        end
        m_v[0] = (pick >= 0);
        m_id[0] = (pick >= 0) ? pick : 0;
        if (pick >= 0) begin
          m_r[0] = fake_res(opa[pick], opb[pick], opc[pick]);
          m_f[0] = fake_flags(opa[pick], opb[pick], opc[pick]);
          m_ptr = (pick + 1) % N;
        end
      end
    end
    for (int c = 0; c <= LAT; c++) begin
      next_cycle();
      Req_SI = '0; Ready_SI = '1;
      #1;
      if ((Valid_SO & Ready_SI) != 4'b0000) n_ret++;
    end
    n_tests++;
    if (n_gnt !== n_ret) begin n_fail++; $display("FAIL rnd_count got %0d retires need %0d grants", n_ret, n_gnt); end
  endtask

  initial begin
    Rst_RI = 1'b1; Req_SI = '0; Ready_SI = '1;
    Operand_a_DI = '0; Operand_b_DI = '0; RM_SI = '0; OP_SI = '0;
    for (int i = 0; i < N; i++) begin opa[i] = '0; opb[i] = '0; oprm[i] = '0; opc[i] = '0; end
    #1;
    test_reset();
    test_single_add();
    test_round_robin();
    test_pointer_wrap();
    test_backpressure();
    test_reset_midflight();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
